fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls program-counter sequencing for the core. Runs the PC through the start, run, halt and fault phases.
- Applies stall, branch, call and return redirects in a fixed priority order.
- Holds a small return-address stack (RAS) for call/return.
- Sits between decode/branch-resolve logic and instruction memory. Drives the fetch address and a fetch-valid qualifier.

Parameters:
IMW, 4, instruction-memory address width (PC width)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse: begin execution at address 0
halt  in  1  decoded halt instruction in the current fetch slot
stall  in  1  freeze PC and RAS this cycle
branch_taken  in  1  resolved branch/jump, redirect to branch_target
call  in  1  call instruction: push return address, redirect to branch_target
ret  in  1  return instruction: pop RAS, redirect to popped address
branch_target  in  IMW  redirect address for branch_taken/call
pc_out  out  IMW  current fetch address
fetch_valid  out  1  pc_out is a valid fetch this cycle
running  out  1  state == RUN
halted  out  1  state == HALTED
fault  out  1  state == FAULT (sticky until start/rst)
ras_ovf  out  1  fault cause: push onto full RAS
ras_unf  out  1  fault cause: pop from empty RAS

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, pc_out=0, RAS count=0, ras_ovf=ras_unf=0.
  - Entries are not cleared; their contents are don't-care.
  - rst overrides every other input in the same cycle.
- States:
  - IDLE: pc held. start -> RUN with pc_out=0.
  - RUN: normal sequencing, described below.
  - HALTED: pc holds the address of the halt instruction. start -> RUN.
  - FAULT: pc holds the faulting address. start -> RUN.
- start (in any non-reset cycle):
  - Next cycle: pc_out=0, RAS count=0, ras_ovf/ras_unf cleared, state=RUN.
  - Overrides all other control inputs.
- fetch_valid = (state==RUN) && !stall. Combinational from state and stall.
- RUN priority, highest first, evaluated once per cycle:
  1. stall: pc and RAS unchanged, no state change. Other inputs are ignored that cycle.
  2. halt: state -> HALTED, pc unchanged.
  3. ret:
     - If count==0: state -> FAULT, ras_unf=1, pc unchanged.
     - Else: pc_out <= top entry, count decrements.
  4. call:
     - If count==RAS_DEPTH: state -> FAULT, ras_ovf=1, pc unchanged.
     - Else: push pc_out+1 (mod 2^IMW), count increments, pc_out <= branch_target.
  5. branch_taken: pc_out <= branch_target.
  6. Otherwise: pc_out <= pc_out+1.
- Same-cycle conflicts:
  - call together with branch_taken is a call; branch_taken is redundant.
  - call together with ret: ret wins and call is dropped. Decode never issues both; the bench still checks this rule.
- Arithmetic:
  - PC increment and pushed return address wrap mod 2^IMW, so 2^IMW-1 -> 0. Wrap is legal, not a fault.
- RAS:
  - LIFO implemented as array + count, depth RAS_DEPTH.
  - Top entry = entry[count-1].
  - Push and pop never happen in the same cycle.
- Latency:
  - A redirect presented in cycle N appears on pc_out in cycle N+1.
  - No stall bubbles are generated internally.
- Inputs outside RUN (except start and rst) are ignored.

Decomposition:
- Shared core package holds:
  - state enum: IDLE=2'd0, RUN=2'd1, HALTED=2'd2, FAULT=2'd3.
  - Default IMW.
- Sub-module ras_stack: parameters IMW, RAS_DEPTH.
  - Ports: clk, rst, push, pop, push_data, top, empty, full.
  - Instantiated once.
- Next-PC mux and FSM stay in fetch_sequencer.

Test Plan:
- Reset then start, no other inputs for 5 cycles -> pc_out 0,1,2,3,4; fetch_valid=1 from the cycle after start.
- IMW=4, run 17 cycles from start -> pc_out wraps 15 -> 0, fault=0.
- Call at pc=3 with target=9, then ret at pc=11 -> pc 9, 10, 11, then 4; RAS count 1 -> 0.
- Five nested calls with RAS_DEPTH=4 -> fifth call gives fault=1, ras_ovf=1, pc frozen. start -> pc=0, running=1, flags clear.
- ret with empty RAS -> fault=1, ras_unf=1. Also: stall held 3 cycles during RUN -> pc constant, fetch_valid=0, then resumes +1.
- halt at pc=6 -> halted=1, pc stays 6. rst asserted mid-RUN at pc=7 -> next cycle IDLE, pc_out=0, fetch_valid=0. Simultaneous start+rst -> IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: phase encoding and default sizing.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam int DEFAULT_IMW       = 4;
    localparam int DEFAULT_RAS_DEPTH = 4;

endpackage

// File: rtl/fetch_sequencer_ras_stack.sv
// Return-address stack: LIFO of IMW-bit addresses kept as an entry array plus a fill count.
module ras_stack
    import fetch_sequencer_pkg::*;
#(
    parameter int IMW       = DEFAULT_IMW,
    parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [IMW-1:0] push_data,
    output logic [IMW-1:0] top,
    output logic           empty,
    output logic           full
);

    localparam int            AW      = $clog2(RAS_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(RAS_DEPTH);

    logic [IMW-1:0] entry_r [RAS_DEPTH];
    logic [AW:0]    count_r;
    logic [AW-1:0]  wr_idx_s;
    logic [AW-1:0]  top_idx_s;
    logic           empty_s;
    logic           full_s;
    logic           do_push_s;
    logic           do_pop_s;

    assign empty_s   = (count_r == (AW+1)'(0));
    assign full_s    = (count_r == DEPTH_C);
    assign wr_idx_s  = count_r[AW-1:0];
    assign top_idx_s = count_r[AW-1:0] - AW'(1);

    // Qualify requests: a push into a full stack or a pop from an empty one never moves the count.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (rst) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else if (pop) begin
            do_pop_s = !empty_s;
        end else begin
            do_push_s = push && !full_s;
        end
    end

    // Fill count; reset empties the stack without touching the entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= (AW+1)'(0);
        end else if (do_push_s) begin
            count_r <= count_r + (AW+1)'(1);
        end else if (do_pop_s) begin
            count_r <= count_r - (AW+1)'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            entry_r[wr_idx_s] <= push_data;
        end
    end

    assign top   = entry_r[top_idx_s];
    assign empty = empty_s;
    assign full  = full_s;

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer: IDLE/RUN/HALTED/FAULT phases, prioritised redirects and call/return via the RAS.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int IMW       = DEFAULT_IMW,
    parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           halt,
    input  logic           stall,
    input  logic           branch_taken,
    input  logic           call,
    input  logic           ret,
    input  logic [IMW-1:0] branch_target,
    output logic [IMW-1:0] pc_out,
    output logic           fetch_valid,
    output logic           running,
    output logic           halted,
    output logic           fault,
    output logic           ras_ovf,
    output logic           ras_unf
);

    state_t         state_r;
    logic [IMW-1:0] pc_r;
    logic           ovf_r;
    logic           unf_r;

    logic [IMW-1:0] pc_inc_s;
    logic [IMW-1:0] ras_top_s;
    logic           ras_empty_s;
    logic           ras_full_s;
    logic           ras_push_s;
    logic           ras_pop_s;
    logic           ras_clear_s;
    logic           slot_active_s;

    // Increment wraps naturally at 2^IMW; the same value is the pushed return address.
    assign pc_inc_s    = pc_r + IMW'(1);
    assign ras_clear_s = rst | start;

    // RAS strobes follow the same priority as the PC mux: ret shadows call, stall/halt shadow both.
    always_comb begin
        slot_active_s = 1'b0;
        ras_push_s    = 1'b0;
        ras_pop_s     = 1'b0;
        if ((state_r == ST_RUN) && !stall && !halt && !start && !rst) begin
            slot_active_s = 1'b1;
        end else begin
            slot_active_s = 1'b0;
        end
        if (slot_active_s && ret) begin
            ras_pop_s = !ras_empty_s;
        end else if (slot_active_s && call) begin
            ras_push_s = !ras_full_s;
        end else begin
            ras_push_s = 1'b0;
            ras_pop_s  = 1'b0;
        end
    end

    ras_stack #(
        .IMW       (IMW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (ras_clear_s),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (pc_inc_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full_s)
    );

    // Phase FSM and next-PC mux; start restarts from address 0 out of any phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= IMW'(0);
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (start) begin
            state_r <= ST_RUN;
            pc_r    <= IMW'(0);
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (stall) begin
                        pc_r <= pc_r;
                    end else if (halt) begin
                        state_r <= ST_HALTED;
                    end else if (ret) begin
                        if (ras_empty_s) begin
                            state_r <= ST_FAULT;
                            unf_r   <= 1'b1;
                        end else begin
                            pc_r <= ras_top_s;
                        end
                    end else if (call) begin
                        if (ras_full_s) begin
                            state_r <= ST_FAULT;
                            ovf_r   <= 1'b1;
                        end else begin
                            pc_r <= branch_target;
                        end
                    end else if (branch_taken) begin
                        pc_r <= branch_target;
                    end else begin
                        pc_r <= pc_inc_s;
                    end
                end
                default: begin
                    state_r <= state_r;
                    pc_r    <= pc_r;
                end
            endcase
        end
    end

    assign pc_out      = pc_r;
    assign fetch_valid = (state_r == ST_RUN) && !stall;
    assign running     = (state_r == ST_RUN);
    assign halted      = (state_r == ST_HALTED);
    assign fault       = (state_r == ST_FAULT);
    assign ras_ovf     = ovf_r;
    assign ras_unf     = unf_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded directed bench: each vector queues its hand-computed expectation; a negedge monitor checks it.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, halt, stall, branch_taken, call, ret;
    logic [3:0] branch_target;
    logic [3:0] pc_out;
    logic       fetch_valid, running, halted, fault, ras_ovf, ras_unf;

    fetch_sequencer #(.IMW(4), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt          (halt),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .call          (call),
        .ret           (ret),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .fetch_valid   (fetch_valid),
        .running       (running),
        .halted        (halted),
        .fault         (fault),
        .ras_ovf       (ras_ovf),
        .ras_unf       (ras_unf)
    );

    always #5 clk = ~clk;

    // Control bits {rst,start,halt,stall,branch_taken,call,ret}
    localparam logic [6:0] N   = 7'b0000000;
    localparam logic [6:0] RST = 7'b1000000;
    localparam logic [6:0] ST  = 7'b0100000;
    localparam logic [6:0] HLT = 7'b0010000;
    localparam logic [6:0] STL = 7'b0001000;
    localparam logic [6:0] BR  = 7'b0000100;
    localparam logic [6:0] CL  = 7'b0000010;
    localparam logic [6:0] RT  = 7'b0000001;

    // Observed flags {fetch_valid,running,halted,fault,ras_ovf,ras_unf}
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_RUN   = 6'b110000;
    localparam logic [5:0] F_STALL = 6'b010000;
    localparam logic [5:0] F_HALT  = 6'b001000;
    localparam logic [5:0] F_OVF   = 6'b000110;
    localparam logic [5:0] F_UNF   = 6'b000101;

    typedef struct packed {
        logic [3:0] pc;
        logic [5:0] flg;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  mon_e;
    string mon_nm;
    logic [5:0] mon_act;
    logic       done = 1'b0;

    // Apply one cycle of inputs; expectation is what the outputs show during this cycle.
    task automatic v(input string nm, input logic [6:0] ctl, input logic [3:0] tgt,
                     input logic [3:0] epc, input logic [5:0] eflg);
        exp_t e;
        {rst, start, halt, stall, branch_taken, call, ret} = ctl;
        branch_target = tgt;
        e.pc  = epc;
        e.flg = eflg;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_act = {fetch_valid, running, halted, fault, ras_ovf, ras_unf};
            n_tests++;
            if (pc_out !== mon_e.pc || mon_act !== mon_e.flg) begin
                n_fail++;
                $display("FAIL %s: got pc_out=%0d flags=%b, expected pc_out=%0d flags=%b",
                         mon_nm, pc_out, mon_act, mon_e.pc, mon_e.flg);
            end
        end
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: sequence did not complete within the wait limit");
            $finish;
        end
    end

    initial begin
        {rst, start, halt, stall, branch_taken, call, ret} = RST;
        branch_target = 4'd0;
        @(posedge clk);
        #1;
        n_tests++;
        if (pc_out !== 4'd0 ||
            {fetch_valid, running, halted, fault, ras_ovf, ras_unf} !== F_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got pc_out=%0d flags=%b, expected pc_out=0 flags=%b",
                     pc_out, {fetch_valid, running, halted, fault, ras_ovf, ras_unf}, F_IDLE);
        end
        v("reset",       RST,          4'd0,  4'd0,  F_IDLE);
        v("idle",        N,            4'd0,  4'd0,  F_IDLE);
        v("idle_ign",    BR | CL | RT, 4'd5,  4'd0,  F_IDLE);
        v("start",       ST,           4'd0,  4'd0,  F_IDLE);
        v("run0",        N,            4'd0,  4'd0,  F_RUN);
        v("run1",        N,            4'd0,  4'd1,  F_RUN);
        v("run2",        N,            4'd0,  4'd2,  F_RUN);
        v("call_at3",    CL,           4'd9,  4'd3,  F_RUN);
        v("pc9",         N,            4'd0,  4'd9,  F_RUN);
        v("pc10",        N,            4'd0,  4'd10, F_RUN);
        v("ret_at11",    RT,           4'd0,  4'd11, F_RUN);
        v("pc4_ret",     N,            4'd0,  4'd4,  F_RUN);
        v("br_at5",      BR,           4'd14, 4'd5,  F_RUN);
        v("pc14",        N,            4'd0,  4'd14, F_RUN);
        v("pc15",        N,            4'd0,  4'd15, F_RUN);
        v("wrap0_stall", STL,          4'd0,  4'd0,  F_STALL);
        v("stall2",      STL | BR,     4'd7,  4'd0,  F_STALL);
        v("stall3",      STL | CL | RT,4'd7,  4'd0,  F_STALL);
        v("resume",      N,            4'd0,  4'd0,  F_RUN);
        v("call_br",     CL | BR,      4'd6,  4'd1,  F_RUN);
        v("halt_stall",  HLT | STL,    4'd0,  4'd6,  F_STALL);
        v("halt_at6",    HLT,          4'd0,  4'd6,  F_RUN);
        v("halted_ign",  BR | CL | RT, 4'd3,  4'd6,  F_HALT);
        v("halted_st",   ST,           4'd0,  4'd6,  F_HALT);
        v("ret_empty",   RT,           4'd0,  4'd0,  F_RUN);
        v("unf",         N,            4'd0,  4'd0,  F_UNF);
        v("unf_ign",     BR | CL,      4'd5,  4'd0,  F_UNF);
        v("unf_st",      ST,           4'd0,  4'd0,  F_UNF);
        v("c1",          CL,           4'd2,  4'd0,  F_RUN);
        v("c2",          CL,           4'd4,  4'd2,  F_RUN);
        v("c3",          CL,           4'd8,  4'd4,  F_RUN);
        v("c4",          CL,           4'd12, 4'd8,  F_RUN);
        v("r4",          RT,           4'd0,  4'd12, F_RUN);
        v("r3",          RT,           4'd0,  4'd9,  F_RUN);
        v("c3b",         CL,           4'd8,  4'd5,  F_RUN);
        v("c4b",         CL,           4'd12, 4'd8,  F_RUN);
        v("c5_full",     CL,           4'd1,  4'd12, F_RUN);
        v("ovf",         RT,           4'd0,  4'd12, F_OVF);
        v("ovf_st",      ST,           4'd0,  4'd12, F_OVF);
        v("call_a",      CL,           4'd10, 4'd0,  F_RUN);
        v("call_ret",    CL | RT,      4'd13, 4'd10, F_RUN);
        v("ret_after",   RT,           4'd0,  4'd1,  F_RUN);
        v("start_rst",   RST | ST,     4'd0,  4'd1,  F_UNF);
        v("idle2",       ST,           4'd0,  4'd0,  F_IDLE);
        v("br7",         BR,           4'd7,  4'd0,  F_RUN);
        v("rst_at7",     RST,          4'd0,  4'd7,  F_RUN);
        v("after_rst",   N,            4'd0,  4'd0,  F_IDLE);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked", exp_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
